// File: rtl/mem_access_pkg.sv
// Shared types and default sizing for the load/store memory access controller.
// Used by mem_access_ctrl and mem_access_addr_check.
package mem_access_pkg;

  localparam int unsigned DEF_MEM_DEPTH = 10;
  localparam int unsigned DEF_DATA_W    = 16;
  localparam int unsigned DEF_ADDR_W    = 8;
  localparam int unsigned STAT_W        = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_CAPTURE,
    ST_RESP
  } state_t;

  // Saturating increment: a counter that has reached all-ones stays there.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/mem_access_addr_check.sv
// Effective-address adder and bounds check for one load/store request.
// The offset is two's complement, so a plain modulo-2^ADDR_W add gives the wrapped address.
module mem_access_addr_check
  import mem_access_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int unsigned ADDR_W    = DEF_ADDR_W
) (
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] offset,
  output logic [ADDR_W-1:0] ea,
  output logic              fault
);

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(MEM_DEPTH);

  assign ea    = base + offset;
  assign fault = ({1'b0, ea} >= DEPTH);

endmodule

// File: rtl/mem_access_ctrl.sv
// Initiator-side load/store controller driving a registered data memory.
// Optional statistics counters are built when MEM_ACCESS_STATS_EN is defined.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned ADDR_W    = DEF_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [ADDR_W-1:0] req_base,
  input  logic [ADDR_W-1:0] req_offset,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_fault,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] sw_value,
  input  logic [DATA_W-1:0] lw_value,
  output logic [15:0]       stat_loads,
  output logic [15:0]       stat_stores,
  output logic [15:0]       stat_faults
);

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] ea;
  logic              fault;
  logic              accept;

  mem_access_addr_check #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_W    (ADDR_W)
  ) u_addr_check (
    .base   (req_base),
    .offset (req_offset),
    .ea     (ea),
    .fault  (fault)
  );

  assign accept = (state == ST_IDLE) && req_valid;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (fault)             next_state = ST_RESP;
          else if (req_is_store) next_state = ST_WRITE;
          else                   next_state = ST_READ;
        end
      end
      ST_WRITE:   next_state = ST_RESP;
      ST_READ:    next_state = ST_CAPTURE;
      ST_CAPTURE: next_state = ST_RESP;
      ST_RESP:    if (rsp_ready) next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == ST_IDLE);
    rsp_valid = (state == ST_RESP);
  end

  // Strobes are registered from next_state so the memory sees flop outputs
  // that line up exactly with the WRITE/READ states.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      addr      <= '0;
      sw_value  <= '0;
      rsp_data  <= '0;
      rsp_fault <= 1'b0;
    end else begin
      mem_write <= (next_state == ST_WRITE);
      mem_read  <= (next_state == ST_READ);
      if (accept) begin
        rsp_fault <= fault;
        rsp_data  <= '0;
        if (!fault) begin
          addr <= ea;
          if (req_is_store) sw_value <= req_wdata;
        end
      end
      if (state == ST_CAPTURE) rsp_data <= lw_value;
    end
  end

`ifdef MEM_ACCESS_STATS_EN
  logic              is_store_q;
  logic [STAT_W-1:0] loads_q;
  logic [STAT_W-1:0] stores_q;
  logic [STAT_W-1:0] faults_q;
  logic              rsp_done;

  assign rsp_done = (state == ST_RESP) && rsp_ready;

  // Counters advance only when the consumer takes the response.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      is_store_q <= 1'b0;
      loads_q    <= '0;
      stores_q   <= '0;
      faults_q   <= '0;
    end else begin
      if (accept) is_store_q <= req_is_store;
      if (rsp_done) begin
        if (rsp_fault)       faults_q <= sat_inc(faults_q);
        else if (is_store_q) stores_q <= sat_inc(stores_q);
        else                 loads_q  <= sat_inc(loads_q);
      end
    end
  end

  assign stat_loads  = loads_q;
  assign stat_stores = stores_q;
  assign stat_faults = faults_q;
`else
  assign stat_loads  = '0;
  assign stat_stores = '0;
  assign stat_faults = '0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl with a registered 10-word data memory.
// Expected responses and statistics come from a word-array model of the memory.
module tb_mem_access_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [7:0]  req_base;
  logic [7:0]  req_offset;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_fault;
  logic        mem_read;
  logic        mem_write;
  logic [7:0]  addr;
  logic [15:0] sw_value;
  logic [15:0] lw_value;
  logic [15:0] stat_loads;
  logic [15:0] stat_stores;
  logic [15:0] stat_faults;

  int vectors     = 0;
  int miscompares = 0;

  logic [15:0] data_mem [10];
  logic [15:0] ref_mem  [10];
  int n_loads, n_stores, n_faults;

  always #5 clock = ~clock;

  mem_access_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_is_store (req_is_store),
    .req_base     (req_base),
    .req_offset   (req_offset),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_fault    (rsp_fault),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .addr         (addr),
    .sw_value     (sw_value),
    .lw_value     (lw_value),
    .stat_loads   (stat_loads),
    .stat_stores  (stat_stores),
    .stat_faults  (stat_faults)
  );

  // Data memory: registered read, cleared by the shared reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 10; i++) data_mem[i] <= '0;
      lw_value <= '0;
    end else begin
      if (mem_write && addr < 8'd10) data_mem[addr[3:0]] <= sw_value;
      if (mem_read && addr < 8'd10) lw_value <= data_mem[addr[3:0]];
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 10; i++) ref_mem[i] = '0;
    n_loads  = 0;
    n_stores = 0;
    n_faults = 0;
  endtask

  task automatic check_stats(input string tag);
`ifdef MEM_ACCESS_STATS_EN
    check_output({tag, "_loads"},  32'(stat_loads),  32'(n_loads));
    check_output({tag, "_stores"}, 32'(stat_stores), 32'(n_stores));
    check_output({tag, "_faults"}, 32'(stat_faults), 32'(n_faults));
`else
    check_output({tag, "_loads"},  32'(stat_loads),  32'd0);
    check_output({tag, "_stores"}, 32'(stat_stores), 32'd0);
    check_output({tag, "_faults"}, 32'(stat_faults), 32'd0);
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check_output({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check_output({tag, "_rsp_fault"}, 32'(rsp_fault), 32'd0);
    check_output({tag, "_rsp_data"},  32'(rsp_data),  32'd0);
    check_output({tag, "_mem_read"},  32'(mem_read),  32'd0);
    check_output({tag, "_mem_write"}, 32'(mem_write), 32'd0);
    check_output({tag, "_addr"},      32'(addr),      32'd0);
    check_output({tag, "_sw_value"},  32'(sw_value),  32'd0);
    check_stats(tag);
  endtask

  // One request end to end: the expected response cycle is 1 for a fault,
  // 2 for a store and 3 for a load, counted from the accept edge.
  task automatic apply_stimulus(input bit is_store, input logic [7:0] base,
                                input logic [7:0] offset, input logic [15:0] wdata,
                                input int hold);
    logic [7:0]  ea;
    bit          fault;
    int          lat;
    logic [15:0] exp_data;
    ea       = base + offset;
    fault    = (ea >= 8'd10);
    lat      = fault ? 1 : (is_store ? 2 : 3);
    exp_data = (fault || is_store) ? 16'h0 : ref_mem[ea[3:0]];

    @(negedge clock);
    check_output("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid    = 1'b1;
    req_is_store = is_store;
    req_base     = base;
    req_offset   = offset;
    req_wdata    = wdata;
    @(negedge clock);
    req_valid    = 1'b0;
    req_is_store = 1'($urandom);
    req_base     = 8'($urandom);
    req_offset   = 8'($urandom);
    req_wdata    = 16'($urandom);

    for (int k = 1; k <= lat; k++) begin
      if (k > 1) @(negedge clock);
      check_output("mem_write", 32'(mem_write), 32'(!fault && is_store && k == 1));
      check_output("mem_read",  32'(mem_read),  32'(!fault && !is_store && k == 1));
      check_output("rsp_valid", 32'(rsp_valid), 32'(k == lat));
      if (k == 1 && !fault) begin
        check_output("addr", 32'(addr), 32'(ea));
        if (is_store) check_output("sw_value", 32'(sw_value), 32'(wdata));
      end
    end
    check_output("rsp_data",  32'(rsp_data),  32'(exp_data));
    check_output("rsp_fault", 32'(rsp_fault), 32'(fault));
    check_output("req_ready_resp", 32'(req_ready), 32'd0);

    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      check_output("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      check_output("hold_rsp_data",  32'(rsp_data),  32'(exp_data));
      check_output("hold_rsp_fault", 32'(rsp_fault), 32'(fault));
      check_output("hold_req_ready", 32'(req_ready), 32'd0);
      check_output("hold_strobes",   32'(mem_read | mem_write), 32'd0);
    end

    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    check_output("post_rsp_valid", 32'(rsp_valid), 32'd0);
    check_output("post_req_ready", 32'(req_ready), 32'd1);

    if (fault) n_faults++;
    else if (is_store) begin
      ref_mem[ea[3:0]] = wdata;
      n_stores++;
    end else n_loads++;
  endtask

  initial begin
    reset        = 1'b1;
    req_valid    = 1'b0;
    req_is_store = 1'b0;
    req_base     = '0;
    req_offset   = '0;
    req_wdata    = '0;
    rsp_ready    = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    check_reset_outputs("reset");
    reset = 1'b0;

    $display("[TB] directed sequence");
    apply_stimulus(1'b1, 8'd3,    8'd0,    16'hBEEF, 0);
    apply_stimulus(1'b0, 8'd3,    8'd0,    16'h0000, 0);
    apply_stimulus(1'b1, 8'd1,    8'd0,    16'h1234, 0);
    apply_stimulus(1'b0, 8'hFF,   8'h02,   16'h0000, 5);
    apply_stimulus(1'b0, 8'd5,    8'h05,   16'h0000, 0);
    apply_stimulus(1'b1, 8'd10,   8'hFF,   16'hA5C3, 1);
    check_stats("stats_directed");

    $display("[TB] randomized sequence");
    for (int i = 0; i < 40; i++) begin
      logic [7:0] target, offset;
      target = 8'($urandom_range(0, 13));
      offset = 8'($urandom);
      apply_stimulus(1'($urandom), target - offset, offset, 16'($urandom),
                     int'($urandom_range(0, 2)));
    end
    check_stats("stats_random");

    $display("[TB] reset during READ");
    @(negedge clock);
    req_valid    = 1'b1;
    req_is_store = 1'b0;
    req_base     = 8'd2;
    req_offset   = 8'd0;
    @(negedge clock);
    req_valid = 1'b0;
    check_output("abort_mem_read", 32'(mem_read), 32'd1);
    reset = 1'b1;
    #1;
    model_reset();
    check_reset_outputs("abort");
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check_output("abort_no_rsp",   32'(rsp_valid), 32'd0);
      check_output("abort_no_strobe", 32'(mem_read | mem_write), 32'd0);
    end
    apply_stimulus(1'b0, 8'd3, 8'd0, 16'h0000, 0);
    check_stats("stats_after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
